flipflop_cntr_n: RTL and testbench
==================================

Name: flipflop_cntr_n

Overview:
- Parametrised, fully synchronous up/down counter; successor to the two-stage JK ripple counter.
- Replaces the ripple chain and separate slow-clock domain with one clock, an internal prescaler that generates a count-enable tick, a programmable modulus, synchronous load, and terminal-count/wrap flags.
- Used as the generic counter for display scan, timing and debounce logic on the lab board.

Parameters:
- WIDTH, 4, bit width of count and din; legal range 1 to 32.
- MODULUS, 10, count range 0..MODULUS-1; legal range 2 to 2**WIDTH.
- PRESCALE, 4, number of enabled clocks per count step; PRESCALE=1 steps on every enabled clock; legal range 1 to 2**16.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  asynchronous reset, active-low.
- en  in  1  count enable; gates the prescaler.
- up  in  1  direction: 1 = up, 0 = down.
- ld  in  1  synchronous load strobe.
- din  in  WIDTH  load value.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational from count and up.
- wrap  out  1  one-cycle registered pulse when count wraps.
- tick  out  1  prescaler step strobe, combinational.

Behaviour:
- Reset (clr=0): count=0, prescaler p=0, wrap=0, applied immediately without a clock edge. Ports clk and clr are one clock with asynchronous active-low reset. Outputs hold these values while clr=0; normal operation starts on the first rising edge after clr returns to 1.
- Prescaler p: width max(1, clog2(PRESCALE)).
  - tick = en AND (p == PRESCALE-1).
  - On a rising edge with en=1: p <= 0 if tick is high, else p <= p+1.
  - With en=0, p holds.
- Edge priority, highest first:
  1. ld=1 (en is ignored): count <= min(din, MODULUS-1), i.e. din >= MODULUS saturates to MODULUS-1; p <= 0; wrap <= 0. This is a load, never a wrap.
  2. tick=1, up=1: count <= 0 if count == MODULUS-1 (wrap <= 1), else count+1 (wrap <= 0).
  3. tick=1, up=0: count <= MODULUS-1 if count == 0 (wrap <= 1), else count-1 (wrap <= 0).
  4. Otherwise: count holds; wrap <= 0.
- wrap: high for exactly one clock, in the cycle after the wrapping edge, aligned with the new count value.
- tc: up ? (count == MODULUS-1) : (count == 0). It follows a change on up in the same cycle.
- Latency: from reset or load with en=1 held, the first count change occurs on the PRESCALE-th rising edge, then every PRESCALE edges after that.
- Direction change: up changing mid-prescale does not reset p; the next tick uses the value of up sampled on that edge.
- MODULUS = 2**WIDTH: wrap arithmetic is natural overflow. The comparison logic must still be used, so behaviour is identical.
- Count values at or above MODULUS are unreachable, because loads saturate.
- No combinational path from din to any output.

Test Plan:
- Reset mid-count: count=6, p=2; assert clr=0 between edges -> count=0 and wrap=0 immediately. Release clr, en=1, up=1 -> count=1 on the 4th edge.
- Up wrap (defaults): en=1, up=1 from reset, 40 edges -> count steps 0..9 on edges 4,8,…,36 and tc=1 while count=9. Edge 40 -> count=0 with wrap=1 for one cycle; wrap is 0 on edge 41.
- Down wrap: from reset, up=0 -> tc=1 at count 0. Edge 4 -> count=9 with wrap=1. Edge 8 -> count=8, tc=0.
- Load and saturation: ld=1 with din=7 for one edge -> count=7, p=0, and the next step (to 8) occurs 4 edges later. ld=1 with din=12 -> count=9. ld on an edge where tick=1 and count=9, up=1 -> count=din and wrap=0.
- Enable hold: with p=2, set en=0 for 10 edges -> count and p unchanged, tick=0. Set en=1 -> count steps on the 2nd edge.
- Parameter sweep: run 3 full wrap cycles each for (WIDTH=1, MODULUS=2, PRESCALE=1), (WIDTH=3, MODULUS=8, PRESCALE=1) and (WIDTH=8, MODULUS=200, PRESCALE=3). Up direction: wrap at count MODULUS-1 -> 0 every MODULUS*PRESCALE edges. Check both directions against a reference model.

Source files
------------

// File: rtl/flipflop_cntr_n.sv
// Synchronous up/down modulo counter with internal prescaler,
// saturating synchronous load and terminal-count / wrap flags.
module flipflop_cntr_n #(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 10,
  parameter int     PRESCALE = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             tick
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PW-1:0] PMAX =
    PW'(PRESCALE - 1);

  localparam logic [WIDTH-1:0] CMAX =
    WIDTH'(MODULUS - 1);

  // One extra bit so MODULUS = 2**WIDTH still fits.
  localparam logic [WIDTH:0] MODW =
    (WIDTH + 1)'(MODULUS);

  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] ld_val;
  logic             at_max;
  logic             at_min;

  assign at_max = (count_q == CMAX);
  assign at_min = (count_q == '0);

  always_comb begin
    tick = en && (p_q == PMAX);
    tc   = up ? at_max : at_min;
  end

  always_comb begin
    if ({1'b0, din} >= MODW) begin
      ld_val = CMAX;
    end else begin
      ld_val = din;
    end
  end

  always_comb begin
    p_d     = p_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (ld) begin
      count_d = ld_val;
      p_d     = '0;
    end else if (tick) begin
      p_d = '0;
      if (up) begin
        if (at_max) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (at_min) begin
          count_d = CMAX;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end else if (en) begin
      p_d = p_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      p_q     <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      p_q     <= p_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_flipflop_cntr_n.sv
// Scoreboard bench: four counter configurations share stimulus
// and are checked against a modular-arithmetic reference model.
module tb_flipflop_cntr_n;

  logic        clk = 1'b0;
  logic        clr;
  logic        en;
  logic        up;
  logic        ld;
  logic [31:0] din;

  logic [3:0] cnt0;
  logic [0:0] cnt1;
  logic [2:0] cnt2;
  logic [7:0] cnt3;
  logic [3:0] tc_a, wr_a, tk_a;

  always #5 clk = ~clk;

  flipflop_cntr_n #(.WIDTH(4), .MODULUS(10), .PRESCALE(4)) u0 (
    .clk(clk), .clr(clr), .en(en), .up(up), .ld(ld),
    .din(din[3:0]), .count(cnt0),
    .tc(tc_a[0]), .wrap(wr_a[0]), .tick(tk_a[0]));

  flipflop_cntr_n #(.WIDTH(1), .MODULUS(2), .PRESCALE(1)) u1 (
    .clk(clk), .clr(clr), .en(en), .up(up), .ld(ld),
    .din(din[0:0]), .count(cnt1),
    .tc(tc_a[1]), .wrap(wr_a[1]), .tick(tk_a[1]));

  flipflop_cntr_n #(.WIDTH(3), .MODULUS(8), .PRESCALE(1)) u2 (
    .clk(clk), .clr(clr), .en(en), .up(up), .ld(ld),
    .din(din[2:0]), .count(cnt2),
    .tc(tc_a[2]), .wrap(wr_a[2]), .tick(tk_a[2]));

  flipflop_cntr_n #(.WIDTH(8), .MODULUS(200), .PRESCALE(3)) u3 (
    .clk(clk), .clr(clr), .en(en), .up(up), .ld(ld),
    .din(din[7:0]), .count(cnt3),
    .tc(tc_a[3]), .wrap(wr_a[3]), .tick(tk_a[3]));

  typedef struct packed {
    logic [3:0][7:0] c;
    logic [3:0]      w;
    logic [3:0]      tc;
    logic [3:0]      tk;
  } exp_t;

  exp_t q[$];

  int MM[4] = '{10, 2, 8, 200};
  int PP[4] = '{4, 1, 1, 3};
  int WW[4] = '{4, 1, 3, 8};

  int mc[4];
  int mp[4];
  bit mw[4];

  int checks = 0;
  int errors = 0;

  logic [3:0][7:0] act_c;
  always_comb begin
    act_c[0] = 8'(cnt0);
    act_c[1] = 8'(cnt1);
    act_c[2] = 8'(cnt2);
    act_c[3] = 8'(cnt3);
  end

  task automatic chk(input string n, input int i,
                     input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s[%0d] @%0t: got %0d expected %0d",
               n, i, $time, a, e);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mc[i] = 0;
      mp[i] = 0;
      mw[i] = 0;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.c[i]  = 8'(mc[i]);
      e.w[i]  = mw[i];
      e.tc[i] = up ? (mc[i] == MM[i] - 1) : (mc[i] == 0);
      e.tk[i] = en && (mp[i] == PP[i] - 1);
    end
    q.push_back(e);
  endtask

  // Effect of one rising edge on the reference state.
  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      int dv;
      bit tk;
      if (!clr) begin
        mc[i] = 0; mp[i] = 0; mw[i] = 0;
      end else if (ld) begin
        dv = int'(din) & ((1 << WW[i]) - 1);
        mc[i] = (dv >= MM[i]) ? MM[i] - 1 : dv;
        mp[i] = 0;
        mw[i] = 0;
      end else begin
        tk = en && (mp[i] == PP[i] - 1);
        mw[i] = 0;
        if (en) mp[i] = tk ? 0 : mp[i] + 1;
        if (tk && up) begin
          mw[i] = (mc[i] == MM[i] - 1);
          mc[i] = (mc[i] + 1) % MM[i];
        end else if (tk) begin
          mw[i] = (mc[i] == 0);
          mc[i] = (mc[i] + MM[i] - 1) % MM[i];
        end
      end
    end
  endtask

  task automatic drive(input bit cl, input bit e, input bit u,
                       input bit l, input logic [31:0] d);
    @(posedge clk);
    #1;
    clr = cl; en = e; up = u; ld = l; din = d;
    if (!cl) model_reset();
    push_exp();
    model_edge();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        for (int i = 0; i < 4; i++) begin
          chk("count", i, int'(act_c[i]), int'(e.c[i]));
          chk("wrap", i, int'(wr_a[i]), int'(e.w[i]));
          chk("tc", i, int'(tc_a[i]), int'(e.tc[i]));
          chk("tick", i, int'(tk_a[i]), int'(e.tk[i]));
        end
      end
    end
  end

  initial begin
    clr = 1'b0; en = 1'b0; up = 1'b1;
    ld = 1'b0; din = '0;
    model_reset();
    repeat (2) drive(0, 0, 1, 0, 0);

    // Count to 6 with prescaler mid-way, then async clear.
    repeat (26) drive(1, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    #1;
    chk("rst_imm_count", 0, int'(cnt0), 0);
    chk("rst_imm_wrap", 0, int'(wr_a[0]), 0);
    chk("rst_imm_count", 3, int'(cnt3), 0);

    // Up through a full wrap.
    repeat (45) drive(1, 1, 1, 0, 0);

    // Down wrap from reset.
    drive(0, 0, 0, 0, 0);
    repeat (10) drive(1, 1, 0, 0, 0);

    // Load, saturation and load on a tick edge.
    drive(1, 0, 1, 1, 7);
    repeat (5) drive(1, 1, 1, 0, 0);
    drive(1, 1, 1, 1, 12);
    repeat (3) drive(1, 1, 1, 0, 0);
    drive(1, 1, 1, 1, 5);

    // Enable hold with prescaler at 2.
    repeat (2) drive(1, 1, 1, 0, 0);
    repeat (10) drive(1, 0, 1, 0, 0);
    repeat (4) drive(1, 1, 1, 0, 0);

    // Long runs covering three wraps of every configuration.
    drive(0, 0, 1, 0, 0);
    repeat (1810) drive(1, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    repeat (1810) drive(1, 1, 0, 0, 0);

    // Random mix.
    repeat (3000) begin
      drive($urandom_range(0, 199) != 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) != 0 ? up : ~up,
            $urandom_range(0, 15) == 0,
            $urandom);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 0, q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
